end_screen_sequencer: RTL and testbench

Sequences the game from live play into the end-of-game screens and drives the final pixel stream. It sits directly upstream of the HDMI/TMDS encoder. It selects between the live game color, a fading version of it, and the win or lose end-screen colors supplied by the end-display generators. The selection is driven by a frame-counted FSM, and the block issues a one-cycle restart pulse back to the game logic.

---
 rtl/end_screen_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_end_screen_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/end_screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : end_screen_sequencer
// Description : Moves the game from live play into the end-of-game screens and
//               produces the final registered pixel stream for the TMDS
//               encoder. The source is chosen by a frame-counted FSM:
//               PLAYING (live color), FADE (live color dimmed one bit per
//               level), END_SHOW (win/lose screen), then RESTART (one-cycle
//               pulse back to the game logic).
//
// Ports       : clk_pixel      pixel clock
//               rst_in         asynchronous active-high reset
//               hcount_in      pixel column (11b)
//               vcount_in      pixel row (10b)
//               new_frame_in   one-cycle start-of-frame pulse
//               game_over_in   game has ended (level)
//               player_won_in  outcome, latched when game_over_in is taken
//               restart_btn_in debounced restart button (level)
//               game_color_in  live game pixel {R,G,B}
//               win_color_in   win end-screen pixel
//               lose_color_in  lose end-screen pixel
//               color_out      registered output pixel
//               hcount_out     hcount_in delayed one cycle
//               vcount_out     vcount_in delayed one cycle
//               state_out      current FSM state
//               won_out        latched outcome
//               restart_out    one-cycle restart pulse
//
// Build option: define END_SCREEN_BLINK_EN to blink the end screen,
//               BLINK_PERIOD_FRAMES frames on, BLINK_PERIOD_FRAMES off.
//
// Revision    : 1.0 - initial release
// ============================================================================
module end_screen_sequencer #(
    parameter int FADE_STEP_FRAMES    = 8,
    parameter int HOLD_FRAMES         = 120,
    parameter int BLINK_PERIOD_FRAMES = 30
) (
    input  logic        clk_pixel,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        new_frame_in,
    input  logic        game_over_in,
    input  logic        player_won_in,
    input  logic        restart_btn_in,
    input  logic [23:0] game_color_in,
    input  logic [23:0] win_color_in,
    input  logic [23:0] lose_color_in,
    output logic [23:0] color_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [1:0]  state_out,
    output logic        won_out,
    output logic        restart_out
);

    typedef enum logic [1:0] {
        PLAYING  = 2'd0,
        FADE     = 2'd1,
        END_SHOW = 2'd2,
        RESTART  = 2'd3
    } state_t;

    localparam int FRAME_W = $clog2(FADE_STEP_FRAMES + 1);
    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FADE_STEP_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_FRAMES);

    state_t              state;
    state_t              next_state;
    logic [FRAME_W-1:0]  frame_cnt;
    logic [2:0]          fade_level;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                won;
    logic                btn_prev;
    logic                btn_rise;
    logic                fade_wrap;
    logic                fade_done;
    logic                blank;
    logic [23:0]         pixel_next;

    assign btn_rise  = restart_btn_in & ~btn_prev;
    assign fade_wrap = new_frame_in && (frame_cnt == FRAME_LAST);
    // Last frame of the darkest level ends the fade.
    assign fade_done = fade_wrap && (fade_level == 3'd7);
    assign blank     = (hcount_in >= 11'd1280) || (vcount_in >= 10'd720);

    assign state_out = state;
    assign won_out   = won;

    // ------------------------------------------------------------------
    // FSM: state register and next-state / pulse decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            state <= PLAYING;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        restart_out = 1'b0;
        case (state)
            PLAYING: begin
                // game_over wins over any restart activity in PLAYING
                if (game_over_in) next_state = FADE;
            end
            FADE: begin
                if (fade_done) next_state = END_SHOW;
            end
            END_SHOW: begin
                if (btn_rise && (hold_cnt == HOLD_MAX)) next_state = RESTART;
            end
            RESTART: begin
                restart_out = 1'b1;
                next_state  = PLAYING;
            end
            default: next_state = PLAYING;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, outcome latch and button sampler
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            frame_cnt  <= '0;
            fade_level <= 3'd0;
            hold_cnt   <= '0;
            won        <= 1'b0;
            btn_prev   <= 1'b0;
        end else begin
            // Sampled in every state so an edge is always measured against
            // a real previous value.
            btn_prev <= restart_btn_in;
            case (state)
                PLAYING: begin
                    if (game_over_in) begin
                        won        <= player_won_in;
                        frame_cnt  <= '0;
                        fade_level <= 3'd0;
                    end
                end
                FADE: begin
                    if (fade_wrap) begin
                        frame_cnt <= '0;
                        if (fade_done) begin
                            fade_level <= 3'd0;
                            hold_cnt   <= '0;
                        end else begin
                            fade_level <= fade_level + 3'd1;
                        end
                    end else if (new_frame_in) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                END_SHOW: begin
                    if (new_frame_in && (hold_cnt != HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RESTART: begin
                    won <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef END_SCREEN_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_PERIOD_FRAMES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (state == FADE && fade_done) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (state == END_SHOW && new_frame_in) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pixel source selection (uses the state in effect at this edge)
    // ------------------------------------------------------------------
    always_comb begin
        pixel_next = game_color_in;
        case (state)
            PLAYING, RESTART: pixel_next = game_color_in;
            FADE: pixel_next = {game_color_in[23:16] >> fade_level,
                                game_color_in[15:8]  >> fade_level,
                                game_color_in[7:0]   >> fade_level};
            END_SHOW: begin
                pixel_next = won ? win_color_in : lose_color_in;
`ifdef END_SCREEN_BLINK_EN
                if (blink_phase) pixel_next = 24'h000000;
`endif
            end
            default: pixel_next = game_color_in;
        endcase
        if (blank) pixel_next = 24'h000000;
    end

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            color_out  <= 24'h000000;
            hcount_out <= 11'd0;
            vcount_out <= 10'd0;
        end else begin
            color_out  <= pixel_next;
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_end_screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_end_screen_sequencer
// Description : Scoreboard bench for end_screen_sequencer. Each driven cycle
//               pushes the expected registered outputs, derived from a
//               frame-counting reference of the game flow; a monitor pops
//               and compares them after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_end_screen_sequencer;

    localparam int FADE_STEP = 8;
    localparam int HOLD      = 120;
    localparam int BLINK     = 30;
    localparam logic [23:0] WIN_C  = 24'h33CC66;
    localparam logic [23:0] LOSE_C = 24'hCC3300;

    logic        clk_pixel = 1'b0;
    logic        rst_in    = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        new_frame_in = 1'b0;
    logic        game_over_in = 1'b0;
    logic        player_won_in = 1'b0;
    logic        restart_btn_in = 1'b0;
    logic [23:0] game_color_in = '0;
    logic [23:0] win_color_in  = WIN_C;
    logic [23:0] lose_color_in = LOSE_C;
    logic [23:0] color_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [1:0]  state_out;
    logic        won_out;
    logic        restart_out;

    end_screen_sequencer #(
        .FADE_STEP_FRAMES(FADE_STEP),
        .HOLD_FRAMES(HOLD),
        .BLINK_PERIOD_FRAMES(BLINK)
    ) dut (
        .clk_pixel(clk_pixel), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .new_frame_in(new_frame_in), .game_over_in(game_over_in),
        .player_won_in(player_won_in), .restart_btn_in(restart_btn_in),
        .game_color_in(game_color_in), .win_color_in(win_color_in),
        .lose_color_in(lose_color_in), .color_out(color_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .state_out(state_out), .won_out(won_out), .restart_out(restart_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [23:0] color;
        logic [10:0] h;
        logic [9:0]  v;
        logic [1:0]  st;
        logic        won;
        logic        rs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference of the game flow, kept as whole-sequence frame counts.
    int   m_state = 0;
    int   m_fade_frames = 0;
    int   m_show_frames = 0;
    logic m_won = 1'b0;
    logic m_btn_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_fade_frames = 0; m_show_frames = 0;
        m_won = 1'b0; m_btn_prev = 1'b0;
    endtask

    // Drive one cycle on the falling edge and queue what the next rising
    // edge must produce.
    task automatic step(input logic [10:0] h, input logic [9:0] v, input logic nf,
                        input logic go, input logic pw, input logic btn,
                        input logic [23:0] gc);
        exp_t e;
        int   lvl;
        logic rise;
        @(negedge clk_pixel);
        hcount_in = h; vcount_in = v; new_frame_in = nf; game_over_in = go;
        player_won_in = pw; restart_btn_in = btn; game_color_in = gc;

        lvl = m_fade_frames / FADE_STEP;
        case (m_state)
            1: e.color = {gc[23:16] >> lvl, gc[15:8] >> lvl, gc[7:0] >> lvl};
            2: begin
                e.color = m_won ? WIN_C : LOSE_C;
`ifdef END_SCREEN_BLINK_EN
                if (((m_show_frames / BLINK) % 2) == 1) e.color = 24'h000000;
`endif
            end
            default: e.color = gc;
        endcase
        if (h >= 11'd1280 || v >= 10'd720) e.color = 24'h000000;

        rise = btn & ~m_btn_prev;
        m_btn_prev = btn;
        case (m_state)
            0: if (go) begin
                m_won = pw; m_fade_frames = 0; m_state = 1;
            end
            1: if (nf) begin
                m_fade_frames++;
                if (m_fade_frames == 8 * FADE_STEP) begin
                    m_state = 2; m_show_frames = 0;
                end
            end
            2: begin
                if (rise && m_show_frames >= HOLD) m_state = 3;
                if (nf) m_show_frames++;
            end
            default: begin
                m_state = 0; m_won = 1'b0;
            end
        endcase

        e.h = h; e.v = v; e.st = 2'(m_state); e.won = m_won; e.rs = (m_state == 3);
        q.push_back(e);
    endtask

    // One frame: start pulse on a visible pixel, then blanked/edge pixels.
    task automatic frame(input logic btn, input logic [23:0] gc);
        step(11'd10,   10'd10,  1'b1, 1'b0, 1'b0, btn, gc);
        step(11'd1280, 10'd5,   1'b0, 1'b0, 1'b0, btn, gc);
        step(11'd1279, 10'd719, 1'b0, 1'b0, 1'b0, btn, gc);
        step(11'd50,   10'd720, 1'b0, 1'b0, 1'b0, btn, gc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_pixel);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("color", 32'(color_out), 32'(e.color));
                check("hcount", 32'(hcount_out), 32'(e.h));
                check("vcount", 32'(vcount_out), 32'(e.v));
                check("state", 32'(state_out), 32'(e.st));
                check("won", 32'(won_out), 32'(e.won));
                check("restart", 32'(restart_out), 32'(e.rs));
            end
        end
    end

    task automatic drain();
        @(posedge clk_pixel);
        #3;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_color"},   32'(color_out), 32'h0);
        check({tag, "_hcount"},  32'(hcount_out), 32'h0);
        check({tag, "_vcount"},  32'(vcount_out), 32'h0);
        check({tag, "_state"},   32'(state_out), 32'h0);
        check({tag, "_won"},     32'(won_out), 32'h0);
        check({tag, "_restart"}, 32'(restart_out), 32'h0);
    endtask

    initial begin : stim
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        rst_in = 1'b0;
        model_reset();

        // Live play, blanking, and restart button ignored in PLAYING
        step(11'd100,  10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
        step(11'd1300, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
        step(11'd100,  10'd800, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
        step(11'd1279, 10'd719, 1'b0, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
        step(11'd200,  10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 24'hABCDEF);

        // game_over coinciding with a restart edge: game_over wins
        step(11'd20, 10'd20, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFF8040);
        for (int i = 0; i < 8 * FADE_STEP; i++) frame(1'b0, 24'hFF8040);

        // END_SHOW: early press ignored, press after hold accepted
        for (int i = 0; i < 50; i++) frame(1'b0, 24'hFF8040);
        for (int i = 0; i < 3; i++)  frame(1'b1, 24'hFF8040);
        for (int i = 0; i < 72; i++) frame(1'b0, 24'hFF8040);
        frame(1'b1, 24'hFF8040);
        frame(1'b0, 24'h0F0F0F);
        step(11'd1, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h00FF00);

        // Button held from END_SHOW entry past saturation
        for (int i = 0; i < 8 * FADE_STEP; i++) frame(i >= 8 * FADE_STEP - 1, 24'h808080);
        for (int i = 0; i < 200; i++) frame(1'b1, 24'h808080);
        frame(1'b0, 24'h808080);
        frame(1'b1, 24'h808080);
        frame(1'b0, 24'h808080);

        // Asynchronous reset in the middle of a fade (level 3)
        step(11'd5, 10'd5, 1'b0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
        for (int i = 0; i < 3 * FADE_STEP + 2; i++) frame(1'b0, 24'hFFFFFF);
        drain();
        rst_in = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        rst_in = 1'b0;

        // Losing game runs through to the lose screen
        step(11'd7, 10'd7, 1'b0, 1'b1, 1'b0, 1'b0, 24'h4080C0);
        for (int i = 0; i < 8 * FADE_STEP + 70; i++) frame(1'b0, 24'h4080C0);

        drain();
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
